// File: rtl/barrier_damage_ctrl.sv
// Barrier block damage tracker: 4 barriers x 4x4 blocks of 2-bit health, serialized
// hit handling (lookup then update) and a one-entry-per-cycle restore sweep.
module barrier_damage_ctrl #(
  parameter logic [1:0] BLK_HP = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_valid,
  output logic       hit_ready,
  input  logic [1:0] hit_barrier,
  input  logic [1:0] hit_x,
  input  logic [1:0] hit_y,
  output logic       hit_done,
  output logic       hit_absorbed,
  input  logic       restore,
  output logic       busy,
  input  logic [1:0] rd_barrier,
  input  logic [1:0] rd_x,
  input  logic [1:0] rd_y,
  output logic [1:0] rd_health,
  output logic       rd_alive,
  output logic [6:0] destroyed_cnt
);
  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESTORE} state_t;

  state_t     state_q;
  logic [1:0] mem_q [64];
  logic [5:0] idx_q, sweep_q;
  logic [1:0] health_q;
  logic       restore_pend_q, hit_done_q, hit_absorbed_q;
  logic [6:0] destroyed_q;

  assign hit_ready     = (state_q == IDLE) && !restore && !restore_pend_q;
  assign busy          = (state_q != IDLE) || restore_pend_q;
  assign hit_done      = hit_done_q;
  assign hit_absorbed  = hit_absorbed_q;
  assign destroyed_cnt = destroyed_q;
  assign rd_health     = mem_q[{rd_barrier, rd_y, rd_x}];
  assign rd_alive      = (rd_health != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      sweep_q        <= '0;
      health_q       <= '0;
      restore_pend_q <= 1'b0;
      hit_done_q     <= 1'b0;
      hit_absorbed_q <= 1'b0;
      destroyed_q    <= '0;
      for (int i = 0; i < 64; i++) mem_q[i] <= BLK_HP;
    end else begin
      hit_done_q     <= 1'b0;
      hit_absorbed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (restore) begin
            state_q     <= RESTORE;
            sweep_q     <= '0;
            destroyed_q <= '0;
          end else if (hit_valid && !restore_pend_q) begin
            idx_q   <= {hit_barrier, hit_y, hit_x};
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          // done/absorbed are registered here so they appear exactly in UPDATE
          health_q       <= mem_q[idx_q];
          hit_done_q     <= 1'b1;
          hit_absorbed_q <= (mem_q[idx_q] != 2'd0);
          if (restore) restore_pend_q <= 1'b1;
          state_q        <= UPDATE;
        end
        UPDATE: begin
          if (health_q != 2'd0) mem_q[idx_q] <= health_q - 2'd1;
          if (restore || restore_pend_q) begin
            state_q        <= RESTORE;
            restore_pend_q <= 1'b0;
            sweep_q        <= '0;
            destroyed_q    <= '0;
          end else begin
            state_q <= IDLE;
            if (health_q == 2'd1 && destroyed_q != 7'd64) destroyed_q <= destroyed_q + 7'd1;
          end
        end
        RESTORE: begin
          mem_q[sweep_q] <= BLK_HP;
          sweep_q        <= sweep_q + 6'd1;
          if (sweep_q == 6'd63) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barrier_damage_ctrl.sv
// Directed bench for barrier_damage_ctrl: hits, saturation, back-to-back, restore and reset paths.
module tb_barrier_damage_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, hit_valid, hit_ready, hit_done, hit_absorbed, restore, busy, rd_alive;
  logic [1:0] hit_barrier, hit_x, hit_y, rd_barrier, rd_x, rd_y, rd_health;
  logic [6:0] destroyed_cnt;
  int checks = 0;
  int failures = 0;

  barrier_damage_ctrl #(.BLK_HP(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_barrier(hit_barrier), .hit_x(hit_x), .hit_y(hit_y), .hit_done(hit_done),
    .hit_absorbed(hit_absorbed), .restore(restore), .busy(busy),
    .rd_barrier(rd_barrier), .rd_x(rd_x), .rd_y(rd_y), .rd_health(rd_health),
    .rd_alive(rd_alive), .destroyed_cnt(destroyed_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] b, input logic [1:0] x, input logic [1:0] y);
    rd_barrier = b; rd_x = x; rd_y = y; #1;
  endtask

  // Counts entries whose health differs from exp across all 64 blocks.
  task automatic mem_all(input string tag, input logic [1:0] exp);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a = 6'(i);
      rd(a[5:4], a[1:0], a[3:2]);
      if (rd_health !== exp) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic hit(input string tag, input logic [1:0] b, input logic [1:0] x,
                     input logic [1:0] y, input logic exp_abs);
    hit_valid = 1'b1; hit_barrier = b; hit_x = x; hit_y = y; #1;
    chk({tag, ".ready"}, hit_ready, 1);
    step();
    hit_valid = 1'b0; hit_barrier = 2'd0; hit_x = 2'd0; hit_y = 2'd0;
    chk({tag, ".lookup_ready"}, hit_ready, 0);
    chk({tag, ".lookup_done"}, hit_done, 0);
    step();
    chk({tag, ".done"}, hit_done, 1);
    chk({tag, ".absorbed"}, hit_absorbed, exp_abs);
    step();
  endtask

  initial begin
    int n;
    int seen_done;
    rst_n = 1'b0; hit_valid = 1'b0; restore = 1'b0;
    hit_barrier = 2'd0; hit_x = 2'd0; hit_y = 2'd0;
    rd_barrier = 2'd0; rd_x = 2'd0; rd_y = 2'd0;
    step(); step();
    rst_n = 1'b1; #1;
    chk("rst.busy", busy, 0);
    chk("rst.ready", hit_ready, 1);
    chk("rst.done", hit_done, 0);
    chk("rst.absorbed", hit_absorbed, 0);
    chk("rst.cnt", destroyed_cnt, 0);
    mem_all("rst.mem", 2'd3);

    // Single hit on barrier 2, x=1, y=3
    hit("single", 2'd2, 2'd1, 2'd3, 1'b1);
    rd(2'd2, 2'd1, 2'd3);
    chk("single.health", rd_health, 2);
    chk("single.alive", rd_alive, 1);
    rd(2'd2, 2'd3, 2'd1);
    chk("single.swapped_xy", rd_health, 3);

    // Destroy and saturate
    hit("sat1", 2'd0, 2'd0, 2'd0, 1'b1);
    hit("sat2", 2'd0, 2'd0, 2'd0, 1'b1);
    hit("sat3", 2'd0, 2'd0, 2'd0, 1'b1);
    chk("sat.cnt_after3", destroyed_cnt, 1);
    hit("sat4", 2'd0, 2'd0, 2'd0, 1'b0);
    rd(2'd0, 2'd0, 2'd0);
    chk("sat.health", rd_health, 0);
    chk("sat.alive", rd_alive, 0);
    chk("sat.cnt", destroyed_cnt, 1);

    // Back-to-back with hit_valid held high; acceptances every 3 cycles
    hit_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      hit_barrier = 2'd1; hit_x = 2'd0; hit_y = 2'(k); #1;
      chk("b2b.ready_accept", hit_ready, 1);
      step();
      chk("b2b.ready_lookup", hit_ready, 0);
      step();
      chk("b2b.ready_update", hit_ready, 0);
      chk("b2b.done", hit_done, 1);
      step();
    end
    hit_valid = 1'b0;
    rd(2'd1, 2'd0, 2'd0); chk("b2b.h0", rd_health, 2);
    rd(2'd1, 2'd0, 2'd2); chk("b2b.h2", rd_health, 2);
    rd(2'd1, 2'd0, 2'd3); chk("b2b.h3_untouched", rd_health, 3);

    // Restore colliding with a hit in IDLE; a restore mid-sweep is ignored
    restore = 1'b1; hit_valid = 1'b1; hit_barrier = 2'd3; hit_x = 2'd3; hit_y = 2'd3; #1;
    chk("coll.ready", hit_ready, 0);
    step();
    restore = 1'b0; hit_valid = 1'b0;
    n = 0; seen_done = 0;
    while (busy && n < 200) begin
      if (hit_done) seen_done++;
      restore = (n == 10);
      n++;
      step();
    end
    restore = 1'b0; #1;
    chk("coll.busy_cycles", n, 64);
    chk("coll.no_done", seen_done, 0);
    chk("coll.cnt", destroyed_cnt, 0);
    chk("coll.ready_after", hit_ready, 1);
    mem_all("coll.mem", 2'd3);

    // Restore during LOOKUP: hit completes, then sweep straight from UPDATE
    hit_valid = 1'b1; hit_barrier = 2'd0; hit_x = 2'd1; hit_y = 2'd2; #1;
    step();
    hit_valid = 1'b0; restore = 1'b1;
    step();
    restore = 1'b0; #1;
    chk("mid.done", hit_done, 1);
    chk("mid.absorbed", hit_absorbed, 1);
    chk("mid.busy_update", busy, 1);
    step();
    chk("mid.done_clear", hit_done, 0);
    chk("mid.ready_restore", hit_ready, 0);
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    chk("mid.sweep_cycles", n, 64);
    rd(2'd0, 2'd1, 2'd2);
    chk("mid.restored", rd_health, 3);

    // Reset at sweep entry 20 with entry 63 damaged
    hit("pre", 2'd3, 2'd3, 2'd3, 1'b1);
    restore = 1'b1; #1;
    step();
    restore = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (hit_done) seen_done++;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; #1;
    if (hit_done) seen_done++;
    chk("rstsw.no_done", seen_done, 0);
    chk("rstsw.busy", busy, 0);
    chk("rstsw.ready", hit_ready, 1);
    chk("rstsw.cnt", destroyed_cnt, 0);
    mem_all("rstsw.mem", 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/barrier_damage_ctrl.md
BARRIER_DAMAGE_CTRL -- requirements
Module: barrier_damage_ctrl

Interface
REQ-001 Parameter BLK_HP, default 3: initial and restore health of every barrier block (2-bit value, 1..3).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 hit_valid  input  1  hit request present.
REQ-005 hit_ready  output  1  block can accept a hit request this cycle.
REQ-006 hit_barrier  input  2  barrier index of the hit (0..3).
REQ-007 hit_x  input  2  block column within the barrier (0..3).
REQ-008 hit_y  input  2  block row within the barrier (0..3).
REQ-009 hit_done  output  1  one-cycle pulse that completes an accepted hit.
REQ-010 hit_absorbed  output  1  valid with hit_done; 1 = block had health > 0 and was damaged.
REQ-011 restore  input  1  level pulse; requests a restore of all 64 blocks to BLK_HP.
REQ-012 busy  output  1  high when state is not IDLE or a restore is pending.
REQ-013 rd_barrier, rd_x, rd_y  input  2 each  renderer read address.
REQ-014 rd_health  output  2  combinational health of the addressed block.
REQ-015 rd_alive  output  1  combinational; rd_health != 0.
REQ-016 destroyed_cnt  output  7  number of blocks at health 0 (0..64).

Function
REQ-017 Storage: 64 entries x 2 bits, index = {barrier, y, x}; the read port has no latency and never stalls.
REQ-018 FSM states: IDLE, LOOKUP, UPDATE, RESTORE.
REQ-019 hit_ready = (state == IDLE) && !restore && !restore_pend.
REQ-020 Handshake: a hit is accepted on a cycle with hit_valid && hit_ready; hit_barrier/x/y are captured that cycle; inputs are don't-care afterward.
REQ-021 IDLE -> LOOKUP on acceptance; LOOKUP registers the stored health of the captured index; LOOKUP -> UPDATE unconditionally.
REQ-022 UPDATE: if captured health > 0, write health-1 and set hit_absorbed=1; else no write and hit_absorbed=0; hit_done=1 for exactly this cycle; UPDATE -> IDLE.
REQ-023 Hit latency: accepted at cycle T, hit_done at T+2, hit_ready high again at T+3 at the earliest.
REQ-024 Health saturates at 0; no wrap to 3.
REQ-025 destroyed_cnt increments by 1 in UPDATE when a write changes health from 1 to 0; never exceeds 64.
REQ-026 restore seen in IDLE: go to RESTORE, clear the sweep counter and destroyed_cnt to 0; restore wins over a simultaneous hit_valid, and that hit is not accepted.
REQ-027 restore seen in LOOKUP or UPDATE: set restore_pend; the in-flight hit completes normally, including hit_done; the next state after UPDATE is RESTORE, and restore_pend is cleared on entry.
REQ-028 RESTORE: write BLK_HP to entry sweep_cnt, one entry per cycle, 0..63; exit to IDLE after writing entry 63; duration exactly 64 cycles.
REQ-029 restore asserted during RESTORE is ignored; no restart and no pending flag.
REQ-030 hit_done and hit_absorbed are 0 in every state except UPDATE.

Reset
REQ-031 When rst_n=0 at a clock edge:
- state=IDLE
- all 64 entries = BLK_HP
- destroyed_cnt=0, restore_pend=0, sweep_cnt=0
- hit_done=0, hit_absorbed=0
- busy=0
- hit_ready=1 on the first cycle after rst_n returns to 1.
REQ-032 Reset mid-hit or mid-RESTORE aborts the operation with no hit_done pulse; all state takes the REQ-031 values.

Verification
REQ-033 Single hit: reset, hit (2,1,3) -> hit_done at T+2, hit_absorbed=1; rd (2,1,3) gives health 2, rd_alive=1.
REQ-034 Destroy and saturate: 4 hits on (0,0,0) -> hit_absorbed 1,1,1,0; final health 0, destroyed_cnt=1, rd_alive=0.
REQ-035 Back-to-back hits: hit_valid held high with new addresses -> acceptances 3 cycles apart; hit_ready low during LOOKUP and UPDATE.
REQ-036 Restore collision: restore and hit_valid in the same IDLE cycle -> no acceptance, busy=1 for 64 cycles, all rd_health=3, destroyed_cnt=0.
REQ-037 Restore mid-hit: restore in LOOKUP -> hit_done still pulses, then RESTORE entered directly from UPDATE; the damaged block reads 3 after the sweep.
REQ-038 Reset mid-RESTORE: rst_n=0 at sweep entry 20 -> all entries 3, state IDLE, no hit_done pulse.
